// File: rtl/aes_keyschedule.sv
// AES-128/192/256 round-key server: expands the key latched during reset and returns any requested round key.
// Zero-cycle combinational lookup with no handshake; AES_KS_EQINV_MIXCOL_EN adds equivalent-inverse-cipher keys.
module aes_keyschedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         inv,
    input  logic [1:0]   aes_len,
    input  logic [255:0] key,
    input  logic [15:0]  subkey_req,
    output logic [127:0] subkey,
    output logic [15:0]  subkey_idx
);

    typedef logic [59:0][31:0] words_t;

    logic [255:0] key_q;
    logic [1:0]   len_q;
    words_t       w;
    int           nk;
    int           nr;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse via x^254 followed by the affine map, avoiding a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, xi;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        xi   = gf_mul(x252, x2);
        return xi ^ {xi[6:0], xi[7]} ^ {xi[5:0], xi[7:6]} ^ {xi[4:0], xi[7:5]}
                  ^ {xi[3:0], xi[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    function automatic words_t expand(input logic [255:0] k, input int nkw);
        words_t     ww;
        logic [31:0] t;
        logic [7:0]  rc;
        int          pos;
        ww  = '0;
        rc  = 8'h01;
        pos = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < nkw) ww[i] = k[255-32*i -: 32];
        end
        for (int i = 4; i < 60; i++) begin
            if (i >= nkw) begin
                t = ww[i-1];
                if (pos == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nkw == 8 && pos == 4) begin
                    t = sub_word(t);
                end
                ww[i] = ww[i-nkw] ^ t;
                pos   = (pos == nkw - 1) ? 0 : pos + 1;
            end
        end
        return ww;
    endfunction

`ifdef AES_KS_EQINV_MIXCOL_EN
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    // Key and length are only sampled while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= key;
            len_q <= aes_len;
        end
    end

    always_comb begin
        nk = 4;
        nr = 10;
        case (len_q)
            2'b10:   begin nk = 6; nr = 12; end
            2'b11:   begin nk = 8; nr = 14; end
            default: begin nk = 4; nr = 10; end
        endcase
    end

    assign w = expand(key_q, nk);

    always_comb begin
        logic [127:0] sel;
        logic         one_hot;
        logic         in_range;
        int           rsel;
        sel      = '0;
        in_range = 1'b0;
        rsel     = 0;
        one_hot  = (subkey_req != 16'h0000) && ((subkey_req & (subkey_req - 16'd1)) == 16'h0000);
        for (int r = 0; r < 15; r++) begin
            if (subkey_req[r] && r <= nr) begin
                sel      = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
                in_range = 1'b1;
                rsel     = r;
            end
        end
`ifdef AES_KS_EQINV_MIXCOL_EN
        if (inv && rsel >= 1 && rsel <= nr - 1) sel = inv_mix_columns(sel);
`endif
        if (one_hot && in_range) begin
            subkey     = sel;
            subkey_idx = subkey_req;
        end else begin
            subkey     = '0;
            subkey_idx = '0;
        end
    end

endmodule

// File: tb/tb_aes_keyschedule.sv
// Directed FIPS-197 vectors against the round-key server, default build (no inverse-MixColumns keys).
module tb_aes_keyschedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         inv;
    logic [1:0]   aes_len;
    logic [255:0] key;
    logic [15:0]  subkey_req;
    logic [127:0] subkey;
    logic [15:0]  subkey_idx;

    int errors = 0;
    int checks = 0;

    aes_keyschedule dut (
        .clk        (clk),
        .rst        (rst),
        .inv        (inv),
        .aes_len    (aes_len),
        .key        (key),
        .subkey_req (subkey_req),
        .subkey     (subkey),
        .subkey_idx (subkey_idx)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefcafef00d0123456789abcdef};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hfeedfacebaadf00d};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] RK128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] RK256 [15] = '{
        128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
        128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
        128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
        128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
        128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
        128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
        128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
        128'hfe4890d1e6188d0b046df344706c631e
    };

    task automatic load(input logic [255:0] k, input logic [1:0] len);
        @(negedge clk);
        rst        = 1'b1;
        key        = k;
        aes_len    = len;
        subkey_req = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic req_chk(input string tag, input logic [15:0] r,
                           input logic [127:0] ek, input logic [15:0] ei);
        @(negedge clk);
        subkey_req = r;
        #1;
        checks++;
        assert ({subkey, subkey_idx} === {ek, ei}) else begin
            errors++;
            $error("FAIL %s: subkey=%h idx=%h expected subkey=%h idx=%h",
                   tag, subkey, subkey_idx, ek, ei);
        end
    endtask

    initial begin
        rst        = 1'b1;
        inv        = 1'b0;
        aes_len    = 2'b01;
        key        = K128;
        subkey_req = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // AES-128: idle output, first key right after reset, full ascending sweep
        req_chk("reset_idle", 16'h0000, 128'h0, 16'h0000);
        req_chk("first_rk0", 16'h0001, K128[255:128], 16'h0001);
        for (int r = 0; r <= 10; r++)
            req_chk($sformatf("aes128_rk%0d", r), 16'(1 << r), RK128[r], 16'(1 << r));
        req_chk("aes128_rk10_spec", 16'h0400, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16'h0400);
        req_chk("aes128_bit11", 16'h0800, 128'h0, 16'h0000);
        req_chk("aes128_multihot", 16'h0003, 128'h0, 16'h0000);
        req_chk("aes128_zero", 16'h0000, 128'h0, 16'h0000);
        req_chk("aes128_bit15", 16'h8000, 128'h0, 16'h0000);

        // Inputs change while rst=0: no effect until the next reset cycle
        @(negedge clk);
        key     = K256;
        aes_len = 2'b11;
        req_chk("hold_rk1", 16'h0002, RK128[1], 16'h0002);
        req_chk("hold_bit14", 16'h4000, 128'h0, 16'h0000);
        load(K256, 2'b11);
        req_chk("reload_rk14", 16'h4000, 128'hfe4890d1e6188d0b046df344706c631e, 16'h4000);

        // AES-256 ascending then descending with inv=1
        for (int r = 0; r <= 14; r++)
            req_chk($sformatf("aes256_up_rk%0d", r), 16'(1 << r), RK256[r], 16'(1 << r));
        inv = 1'b1;
        for (int r = 14; r >= 0; r--)
            req_chk($sformatf("aes256_dn_rk%0d", r), 16'(1 << r), RK256[r], 16'(1 << r));
        inv = 1'b0;
        req_chk("aes256_bit15", 16'h8000, 128'h0, 16'h0000);
        req_chk("aes256_rk2_spec", 16'h0004, 128'h9ba354118e6925afa51a8b5f2067fcde, 16'h0004);

        // AES-192 with junk in the ignored LSBs
        load(K192, 2'b10);
        req_chk("aes192_rk0", 16'h0001, 128'h000102030405060708090a0b0c0d0e0f, 16'h0001);
        req_chk("aes192_rk1", 16'h0002, 128'h10111213141516175846f2f95c43f4fe, 16'h0002);
        req_chk("aes192_rk12", 16'h1000, 128'ha4970a331a78dc09c418c271e3a41d5d, 16'h1000);
        req_chk("aes192_bit13", 16'h2000, 128'h0, 16'h0000);
        req_chk("aes192_multihot", 16'h1001, 128'h0, 16'h0000);

        // aes_len=00 behaves as AES-128
        load(K128, 2'b00);
        req_chk("len00_rk10", 16'h0400, RK128[10], 16'h0400);
        req_chk("len00_bit11", 16'h0800, 128'h0, 16'h0000);
        req_chk("len00_rk5", 16'h0020, RK128[5], 16'h0020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
